twos_complement_serial: RTL and testbench

Parametrised, handshaked successor to the team's fixed 6-bit combinational negator. It accepts one WIDTH-bit operand plus an operation mode: pass, negate, absolute value, or sign-magnitude-to-two's-complement. The result is computed CHUNK bits per cycle through a carry-chained serial datapath, so wide words are handled without a full-width adder. It sits between operand producers and the arithmetic units as a valid/ready stage and flags the unrepresentable most-negative case.

---
 rtl/twos_complement_serial_if.sv | 25 ++
 rtl/twos_complement_serial.sv | 168 ++++++++++++++++
 tb/tb_twos_complement_serial.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/twos_complement_serial_if.sv
// Handshake bundle for the serial two's-complement stage: operand side
// (in_*) and result side (out_*). The master drives operands and consumes
// results; the slave is the stage itself.
interface twos_complement_serial_if #(
  parameter int WIDTH = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/twos_complement_serial.sv
// Serial two's-complement stage: pass / negate / abs / sign-magnitude
// conversion of a WIDTH-bit operand, CHUNK bits per cycle through a
// carry-chained datapath, behind a valid/ready handshake.

// One bit of the chunk datapath: conditionally inverted input plus carry.
// There is no second addend, so each bit is a half adder.
module tcs_bit_cell (
  input  logic x_i,
  input  logic inv_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  logic xi;
  assign xi  = x_i ^ inv_i;
  assign s_o = xi ^ c_i;
  assign c_o = xi & c_i;
endmodule

module twos_complement_serial #(
  parameter int WIDTH = 6,
  parameter int CHUNK = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  twos_complement_serial_if.slave bus
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0]    LAST    = CW'(NCH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [1:0] M_PASS = 2'b00;
  localparam logic [1:0] M_NEG  = 2'b01;
  localparam logic [1:0] M_ABS  = 2'b10;
  localparam logic [1:0] M_SM   = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] x_q;        // unprocessed operand bits, consumed from the bottom
  logic [WIDTH-1:0] res_q;      // result bits, filled in from the top
  logic             inv_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             ovf_pend_q; // overflow decided at accept, published in DONE
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_ovf_q;

  // Accept-time decode: effective operand, invert/carry-in, overflow case.
  // inv and carry-in are always equal, so one signal seeds both.
  logic [WIDTH-1:0] op_sel;
  logic             inv_sel;
  logic             ovf_sel;
  logic             msb;

  // Decode mode and operand MSB into the datapath controls.
  always_comb begin
    msb     = bus.in_data[WIDTH-1];
    op_sel  = bus.in_data;
    inv_sel = 1'b0;
    ovf_sel = 1'b0;
    case (bus.in_mode)
      M_PASS: ;
      M_NEG: begin
        inv_sel = 1'b1;
        ovf_sel = (bus.in_data == MIN_VAL);
      end
      M_ABS: begin
        inv_sel = msb;
        ovf_sel = (bus.in_data == MIN_VAL);
      end
      M_SM: begin
        // Strip the sign; negative zero then wraps to all-zero naturally.
        op_sel  = {1'b0, bus.in_data[WIDTH-2:0]};
        inv_sel = msb;
      end
      default: ;
    endcase
  end

  // Chunk datapath: ripple the carry through CHUNK bit cells.
  logic [CHUNK:0]   cy;
  logic [CHUNK-1:0] sum;
  assign cy[0] = carry_q;

  for (genvar g = 0; g < CHUNK; g++) begin : g_cell
    tcs_bit_cell u_cell (
      .x_i  (x_q[g]),
      .inv_i(inv_q),
      .c_i  (cy[g]),
      .s_o  (sum[g]),
      .c_o  (cy[g+1])
    );
  end

  // New chunk enters at the top; after NCH shifts bit 0 of the result is at bit 0.
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] x_d;
  assign res_d = (res_q >> CHUNK) | (WIDTH'(sum) << (WIDTH - CHUNK));
  assign x_d   = x_q >> CHUNK;

  // Control FSM with registered handshake outputs and the serial datapath state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      res_q       <= '0;
      inv_q       <= 1'b0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      ovf_pend_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            x_q        <= op_sel;
            res_q      <= '0;
            inv_q      <= inv_sel;
            carry_q    <= inv_sel;
            cnt_q      <= '0;
            ovf_pend_q <= ovf_sel;
            in_ready_q <= 1'b0;
            state_q    <= S_BUSY;
          end
        end
        S_BUSY: begin
          x_q     <= x_d;
          res_q   <= res_d;
          carry_q <= cy[CHUNK];
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            // Final carry-out is dropped: arithmetic is modulo 2^WIDTH.
            out_valid_q <= 1'b1;
            out_data_q  <= res_d;
            out_ovf_q   <= ovf_pend_q;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_ovf_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          out_ovf_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_twos_complement_serial.sv
// Directed bench for twos_complement_serial: WIDTH=6/CHUNK=2 main instance
// plus WIDTH=8 instances with CHUNK=1,4,8 driven in parallel.
module tb_twos_complement_serial;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  twos_complement_serial_if #(.WIDTH(6)) b6 ();
  twos_complement_serial #(.WIDTH(6), .CHUNK(2)) dut6 (.clk(clk), .rst_n(rst_n), .bus(b6));

  twos_complement_serial_if #(.WIDTH(8)) b8a ();
  twos_complement_serial_if #(.WIDTH(8)) b8b ();
  twos_complement_serial_if #(.WIDTH(8)) b8c ();
  twos_complement_serial #(.WIDTH(8), .CHUNK(1)) dut8a (.clk(clk), .rst_n(rst_n), .bus(b8a));
  twos_complement_serial #(.WIDTH(8), .CHUNK(4)) dut8b (.clk(clk), .rst_n(rst_n), .bus(b8b));
  twos_complement_serial #(.WIDTH(8), .CHUNK(8)) dut8c (.clk(clk), .rst_n(rst_n), .bus(b8c));

  logic       v8, o8r;
  logic [7:0] d8;
  logic [1:0] m8;
  assign b8a.in_valid = v8;  assign b8a.in_data = d8;  assign b8a.in_mode = m8;  assign b8a.out_ready = o8r;
  assign b8b.in_valid = v8;  assign b8b.in_data = d8;  assign b8b.in_mode = m8;  assign b8b.out_ready = o8r;
  assign b8c.in_valid = v8;  assign b8c.in_data = d8;  assign b8c.in_mode = m8;  assign b8c.out_ready = o8r;

  logic [2:0]      ov8, of8;
  logic [2:0][7:0] od8;
  assign ov8 = {b8c.out_valid, b8b.out_valid, b8a.out_valid};
  assign of8 = {b8c.out_ovf, b8b.out_ovf, b8a.out_ovf};
  assign od8 = {b8c.out_data, b8b.out_data, b8a.out_data};

  // Reference: {ovf, result} for a w-bit operand (w <= 8).
  function automatic logic [8:0] model(input logic [7:0] x, input logic [1:0] m, input int w);
    logic [7:0] mask, minv, mag;
    logic       neg;
    mask = 8'((1 << w) - 1);
    minv = 8'(1 << (w - 1));
    neg  = (x & minv) != 8'd0;
    case (m)
      2'b00:   return {1'b0, x & mask};
      2'b01:   return {x == minv, (8'd0 - x) & mask};
      2'b10:   return neg ? {x == minv, (8'd0 - x) & mask} : {1'b0, x};
      default: begin
        mag = x & (minv - 8'd1);
        return {1'b0, neg ? ((8'd0 - mag) & mask) : mag};
      end
    endcase
  endfunction

  task automatic send6(input logic [5:0] d, input logic [1:0] m);
    @(negedge clk);
    b6.in_valid = 1'b1; b6.in_data = d; b6.in_mode = m;
    @(negedge clk);
    b6.in_valid = 1'b0;
  endtask

  // Cycles from accept edge until out_valid is seen; 20 means it never came.
  task automatic wait6(output int lat);
    lat = 0;
    while (!b6.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic pop6;
    b6.out_ready = 1'b1;
    @(negedge clk);
    b6.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (b6.in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b want 1", b6.in_ready); end
    checks++; if (b6.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", b6.out_valid); end
    checks++; if (b6.out_data !== 6'd0)  begin errors++; $display("FAIL reset_out_data got %b want 000000", b6.out_data); end
    checks++; if (b6.out_ovf !== 1'b0)   begin errors++; $display("FAIL reset_out_ovf got %b want 0", b6.out_ovf); end
    rst_n = 1'b1;
  endtask

  task automatic test_vectors;
    logic [5:0] vd [10] = '{6'b000101, 6'b000000, 6'b100000, 6'b100000, 6'b111011,
                            6'b000111, 6'b101010, 6'b100101, 6'b000101, 6'b100000};
    logic [1:0] vm [10] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00, 2'b11, 2'b11, 2'b11};
    logic [5:0] ed [10] = '{6'b111011, 6'b000000, 6'b100000, 6'b100000, 6'b000101,
                            6'b000111, 6'b101010, 6'b111011, 6'b000101, 6'b000000};
    logic       eo [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int lat;
    for (int i = 0; i < 10; i++) begin
      send6(vd[i], vm[i]);
      wait6(lat);
      checks++; if (lat != 3) begin errors++; $display("FAIL vec%0d_latency got %0d want 3", i, lat); end
      checks++; if (b6.out_data !== ed[i]) begin errors++; $display("FAIL vec%0d_data got %b want %b", i, b6.out_data, ed[i]); end
      checks++; if (b6.out_ovf !== eo[i]) begin errors++; $display("FAIL vec%0d_ovf got %b want %b", i, b6.out_ovf, eo[i]); end
      pop6();
      checks++; if (b6.out_valid !== 1'b0 || b6.out_ovf !== 1'b0 || b6.in_ready !== 1'b1)
        begin errors++; $display("FAIL vec%0d_release got v=%b o=%b r=%b want 0 0 1", i, b6.out_valid, b6.out_ovf, b6.in_ready); end
    end
  endtask

  task automatic test_backpressure;
    int lat;
    send6(6'b010110, 2'b01);  // -22 mod 64 = 42
    wait6(lat);
    for (int c = 0; c < 5; c++) begin
      b6.in_valid = 1'b1; b6.in_data = 6'b000001; b6.in_mode = 2'b00;
      checks++; if (b6.out_valid !== 1'b1 || b6.out_data !== 6'b101010 || b6.in_ready !== 1'b0)
        begin errors++; $display("FAIL bp_hold%0d got v=%b d=%b r=%b want 1 101010 0", c, b6.out_valid, b6.out_data, b6.in_ready); end
      @(negedge clk);
    end
    b6.in_valid = 1'b0;
    pop6();
    checks++; if (b6.out_valid !== 1'b0 || b6.in_ready !== 1'b1)
      begin errors++; $display("FAIL bp_release got v=%b r=%b want 0 1", b6.out_valid, b6.in_ready); end
  endtask

  task automatic test_input_hold;
    int lat;
    send6(6'b000101, 2'b01);
    lat = 0;
    while (!b6.out_valid && lat < 20) begin
      b6.in_valid = 1'b1; b6.in_data = 6'($urandom); b6.in_mode = 2'($urandom);
      @(negedge clk);
      lat++;
    end
    b6.in_valid = 1'b0;
    checks++; if (lat != 3) begin errors++; $display("FAIL hold_latency got %0d want 3", lat); end
    checks++; if (b6.out_data !== 6'b111011) begin errors++; $display("FAIL hold_data got %b want 111011", b6.out_data); end
    pop6();
  endtask

  task automatic test_async_reset;
    int lat, seen;
    send6(6'b000011, 2'b01);
    #2 rst_n = 1'b0;  // mid-cycle, away from any clock edge
    #1;
    checks++; if (b6.in_ready !== 1'b1 || b6.out_valid !== 1'b0 || b6.out_data !== 6'd0 || b6.out_ovf !== 1'b0)
      begin errors++; $display("FAIL arst_outputs got r=%b v=%b d=%b o=%b want 1 0 000000 0", b6.in_ready, b6.out_valid, b6.out_data, b6.out_ovf); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (b6.out_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL arst_no_output got %0d valid cycles want 0", seen); end
    send6(6'b000011, 2'b01);
    wait6(lat);
    checks++; if (lat != 3 || b6.out_data !== 6'b111101)
      begin errors++; $display("FAIL arst_next got lat=%0d d=%b want 3 111101", lat, b6.out_data); end
    pop6();
  endtask

  task automatic test_back_to_back;
    logic [5:0] vd [4] = '{6'b000001, 6'b111111, 6'b100011, 6'b011111};
    logic [1:0] vm [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    logic [5:0] ed [4] = '{6'b111111, 6'b000001, 6'b111101, 6'b011111};
    int si = 0, ri = 0, last_t = -1;
    logic acc;
    b6.out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && ri < 4; cyc++) begin
      if (b6.out_valid) begin
        checks++; if (b6.out_data !== ed[ri] || b6.out_ovf !== 1'b0)
          begin errors++; $display("FAIL b2b%0d_data got %b/%b want %b/0", ri, b6.out_data, b6.out_ovf, ed[ri]); end
        if (last_t >= 0) begin
          checks++; if (cyc - last_t < 4) begin errors++; $display("FAIL b2b%0d_spacing got %0d want >=4", ri, cyc - last_t); end
        end
        last_t = cyc;
        ri++;
      end
      if (ri >= 4) break;
      if (si < 4) begin b6.in_valid = 1'b1; b6.in_data = vd[si]; b6.in_mode = vm[si]; end
      else b6.in_valid = 1'b0;
      acc = b6.in_valid && b6.in_ready;
      @(negedge clk);
      if (acc) si++;
    end
    b6.in_valid = 1'b0;
    @(negedge clk);
    b6.out_ready = 1'b0;
    checks++; if (ri != 4) begin errors++; $display("FAIL b2b_count got %0d want 4", ri); end
  endtask

  // Drive one operand into all three WIDTH=8 instances; record first out_valid per instance.
  task automatic run8(input logic [7:0] d, input logic [1:0] m,
                      output logic [2:0][4:0] lat, output logic [2:0][7:0] od, output logic [2:0] of);
    logic [2:0] got;
    got = '0; lat = '1; od = '0; of = '0;
    o8r = 1'b1;
    @(negedge clk);
    v8 = 1'b1; d8 = d; m8 = m;
    @(negedge clk);
    v8 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (!got[k] && ov8[k]) begin
          got[k] = 1'b1; lat[k] = 5'(c); od[k] = od8[k]; of[k] = of8[k];
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sweep;
    int exp_lat [3] = '{8, 2, 1};
    logic [2:0][4:0] lat;
    logic [2:0][7:0] od;
    logic [2:0]      of;
    logic [7:0] d;
    logic [1:0] m;
    logic [8:0] e;
    run8(8'h01, 2'b01, lat, od, of);
    for (int k = 0; k < 3; k++) begin
      checks++; if (int'(lat[k]) != exp_lat[k]) begin errors++; $display("FAIL sweep%0d_neg01_latency got %0d want %0d", k, lat[k], exp_lat[k]); end
      checks++; if (od[k] !== 8'hFF || of[k] !== 1'b0) begin errors++; $display("FAIL sweep%0d_neg01 got %h/%b want ff/0", k, od[k], of[k]); end
    end
    run8(8'h80, 2'b01, lat, od, of);
    for (int k = 0; k < 3; k++) begin
      checks++; if (od[k] !== 8'h80 || of[k] !== 1'b1) begin errors++; $display("FAIL sweep%0d_neg80 got %h/%b want 80/1", k, od[k], of[k]); end
    end
    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom); m = 2'($urandom);
      if (i % 8 == 0) d = 8'h80;
      e = model(d, m, 8);
      run8(d, m, lat, od, of);
      for (int k = 0; k < 3; k++) begin
        checks++; if (int'(lat[k]) != exp_lat[k] || od[k] !== e[7:0] || of[k] !== e[8])
          begin errors++; $display("FAIL sweep%0d_rand%0d in=%h mode=%0d got lat=%0d %h/%b want lat=%0d %h/%b",
                                   k, i, d, m, lat[k], od[k], of[k], exp_lat[k], e[7:0], e[8]); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    b6.in_valid = 1'b0; b6.in_data = '0; b6.in_mode = '0; b6.out_ready = 1'b0;
    v8 = 1'b0; d8 = '0; m8 = '0; o8r = 1'b0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_input_hold();
    test_async_reset();
    test_back_to_back();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
